// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the units that consume its contents.
// The execution unit's result and FSM state types live here beside the instruction format.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StOut
  } exec_state_t;

  function automatic result_t sext_operand(operand_t op);
    return {{32{op[31]}}, op};
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational executor for one instruction: all arithmetic is done on 64-bit
// sign-extended operands so the product and quotient never overflow.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  result,
  output logic     div_by_zero
);

  result_t a_ext;
  result_t b_ext;
  logic    b_is_zero;

  assign a_ext     = sext_operand(op_a);
  assign b_ext     = sext_operand(op_b);
  assign b_is_zero = (op_b == '0);

  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (opc)
      ZERO:  result = '0;
      PASSA: result = a_ext;
      PASSB: result = b_ext;
      ADD:   result = a_ext + b_ext;
      SUB:   result = a_ext - b_ext;
      MULT:  result = a_ext * b_ext;
      DIV: begin
        if (b_is_zero) begin
          div_by_zero = 1'b1;
        end else begin
          result = a_ext / b_ext;
        end
      end
      MOD: begin
        // Signed % keeps the dividend's sign, which is the behaviour we want.
        if (b_is_zero) begin
          div_by_zero = 1'b1;
        end else begin
          result = a_ext % b_ext;
        end
      end
      default: begin
        result      = '0;
        div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_exec_unit.sv
// Walks a range of instruction register locations, executes each instruction and
// presents one result per instruction on a valid/ready port.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int unsigned PTR_W = 5,
  parameter int unsigned CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PTR_W-1:0]  start_ptr,
  input  logic [CNT_W-1:0]  count,
  output logic [PTR_W-1:0]  read_pointer,
  input  instruction_t      instruction_word,
  output result_t           result,
  output logic [PTR_W-1:0]  res_ptr,
  output logic              div_by_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done
);

  exec_state_t      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  result_t          result_q, result_d;
  logic [PTR_W-1:0] res_ptr_q, res_ptr_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  result_t          alu_result;
  logic             alu_dz;

  instr_alu u_alu (
    .opc         (instruction_word.opc),
    .op_a        (instruction_word.op_a),
    .op_b        (instruction_word.op_b),
    .result      (alu_result),
    .div_by_zero (alu_dz)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    result_d    = result_q;
    res_ptr_d   = res_ptr_q;
    dz_d        = dz_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count != '0) begin
            ptr_d       = start_ptr;
            remaining_d = count;
            state_d     = StFetch;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      // One full cycle of read_pointer before the word is sampled.
      StFetch: state_d = StExec;
      StExec: begin
        result_d  = alu_result;
        dz_d      = alu_dz;
        res_ptr_d = ptr_q;
        state_d   = StOut;
      end
      StOut: begin
        if (res_ready) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      result_q    <= '0;
      res_ptr_q   <= '0;
      dz_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      result_q    <= result_d;
      res_ptr_q   <= res_ptr_d;
      dz_q        <= dz_d;
      done_q      <= done_d;
    end
  end

  assign read_pointer = ptr_q;
  assign result       = result_q;
  assign res_ptr      = res_ptr_q;
  assign div_by_zero  = dz_q;
  assign res_valid    = (state_q == StOut);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench for instr_exec_unit: directed vector table, multi-cycle corner
// sequences and randomized runs against a behavioural model of the instruction semantics.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  localparam int PTR_W = 5;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [PTR_W-1:0] start_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] read_pointer;
  instruction_t     instruction_word;
  result_t          result;
  logic [PTR_W-1:0] res_ptr;
  logic             div_by_zero;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             done;

  instruction_t mem [32];

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint r;
    int     p;
    bit     dz;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    opcode_t opc;
    int      a;
    int      b;
    longint  r;
    bit      dz;
  } vec_t;
  localparam int NumVecs = 14;
  vec_t vecs [NumVecs];

  instr_exec_unit #(
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_ptr        (start_ptr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .result           (result),
    .res_ptr          (res_ptr),
    .div_by_zero      (div_by_zero),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Instruction register with one cycle of read latency.
  always @(posedge clk) instruction_word <= mem[read_pointer];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(got), $signed(want));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction semantics straight from the arithmetic rules, on 64-bit integers.
  function automatic void ref_exec(input instruction_t w, output longint r, output bit dz);
    longint a;
    longint b;
    a  = longint'(w.op_a);
    b  = longint'(w.op_b);
    r  = 0;
    dz = 1'b0;
    case (w.opc)
      PASSA: r = a;
      PASSB: r = b;
      ADD:   r = a + b;
      SUB:   r = a - b;
      MULT:  r = a * b;
      DIV:   if (b == 0) dz = 1'b1; else r = a / b;
      MOD:   if (b == 0) dz = 1'b1; else r = a % b;
      default: r = 0;
    endcase
  endfunction

  // Runs one instruction range; exp_q must hold cnt expected results in order.
  task automatic do_run(input int sp, input int cnt, input int stall, input bit poke);
    exp_t e;
    int   t;
    int   ns;
    start     = 1'b1;
    start_ptr = PTR_W'(sp);
    count     = CNT_W'(cnt);
    tick();
    start = 1'b0;
    chk("busy_at_n1", 64'(busy), 64'(1));
    chk("valid_at_n1", 64'(res_valid), 64'(0));
    if (poke) begin
      start     = 1'b1;
      start_ptr = PTR_W'(7);
      count     = CNT_W'(1);
    end
    tick();
    start = 1'b0;
    chk("valid_at_n2", 64'(res_valid), 64'(0));
    tick();
    chk("valid_at_n3", 64'(res_valid), 64'(1));
    for (int i = 0; i < cnt; i++) begin
      t = 0;
      while (!res_valid && t < 10) begin
        tick();
        t++;
      end
      if (!res_valid) begin
        chk("valid_timeout", 64'(res_valid), 64'(1));
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      chk("result", result, e.r);
      chk("res_ptr", 64'(res_ptr), 64'(e.p));
      chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
      chk("read_pointer", 64'(read_pointer), 64'(e.p));
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      res_ready = 1'b0;
      for (int k = 0; k < ns; k++) begin
        tick();
        chk("hold_valid", 64'(res_valid), 64'(1));
        chk("hold_result", result, e.r);
        chk("hold_res_ptr", 64'(res_ptr), 64'(e.p));
        chk("hold_read_pointer", 64'(read_pointer), 64'(e.p));
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      if (i < cnt - 1) chk("no_early_done", 64'(done), 64'(0));
    end
    chk("done_after_last", 64'(done), 64'(1));
    chk("idle_after_last", 64'(busy), 64'(0));
    chk("no_extra_valid", 64'(res_valid), 64'(0));
    tick();
    chk("done_one_cycle", 64'(done), 64'(0));
    exp_q.delete();
  endtask

  task automatic fill_random(input int sp, input int cnt);
    instruction_t w;
    longint       r;
    bit           dz;
    int           loc;
    for (int i = 0; i < cnt; i++) begin
      loc      = (sp + i) % 32;
      w.opc    = opcode_t'($urandom_range(0, 9));
      w.op_a   = $signed($urandom) >>> 2;
      w.op_b   = ($urandom_range(0, 5) == 0) ? 0 : ($signed($urandom) >>> 2);
      mem[loc] = w;
      ref_exec(w, r, dz);
      exp_q.push_back('{r: r, p: loc, dz: dz});
    end
  endtask

  initial begin
    vecs[0]  = '{ADD,   5,           3,           64'sd8,                   1'b0};
    vecs[1]  = '{SUB,   -7,          4,           -64'sd11,                 1'b0};
    vecs[2]  = '{MULT,  -15,         15,          -64'sd225,                1'b0};
    vecs[3]  = '{DIV,   7,           0,           64'sd0,                   1'b1};
    vecs[4]  = '{MOD,   -7,          2,           -64'sd1,                  1'b0};
    vecs[5]  = '{DIV,   -7,          2,           -64'sd3,                  1'b0};
    vecs[6]  = '{MOD,   7,           0,           64'sd0,                   1'b1};
    vecs[7]  = '{PASSA, -123,        9,           -64'sd123,                1'b0};
    vecs[8]  = '{PASSB, 4,           -2147483647 - 1, -64'sd2147483648,     1'b0};
    vecs[9]  = '{ZERO,  55,          66,          64'sd0,                   1'b0};
    vecs[10] = '{MULT,  2147483647,  2147483647,  64'sd4611686014132420609, 1'b0};
    vecs[11] = '{MOD,   7,           -3,          64'sd1,                   1'b0};
    vecs[12] = '{opcode_t'(4'd12), 3, 4,          64'sd0,                   1'b0};
    vecs[13] = '{DIV,   -2147483647 - 1, 2,       -64'sd1073741824,         1'b0};

    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset_n   = 1'b0;
    start     = 1'b0;
    start_ptr = '0;
    count     = '0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_read_pointer", 64'(read_pointer), 64'(0));
    chk("rst_result", result, 64'(0));
    chk("rst_res_ptr", 64'(res_ptr), 64'(0));
    chk("rst_div_by_zero", 64'(div_by_zero), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    reset_n = 1'b1;
    tick();

    // Basic three-instruction run with res_ready held high.
    for (int i = 0; i < 3; i++) begin
      mem[i] = '{opc: vecs[i].opc, op_a: vecs[i].a, op_b: vecs[i].b};
      exp_q.push_back('{r: vecs[i].r, p: i, dz: vecs[i].dz});
    end
    do_run(0, 3, 0, 1'b0);

    // Whole vector table in one run.
    for (int i = 0; i < NumVecs; i++) begin
      mem[i] = '{opc: vecs[i].opc, op_a: vecs[i].a, op_b: vecs[i].b};
      exp_q.push_back('{r: vecs[i].r, p: i, dz: vecs[i].dz});
    end
    do_run(0, NumVecs, 0, 1'b0);

    // Pointer wrap with a start pulse injected while busy.
    fill_random(30, 4);
    do_run(30, 4, 0, 1'b1);

    // Long backpressure on every result.
    fill_random(5, 2);
    do_run(5, 2, 10, 1'b0);

    // Zero-length run: done pulse only.
    start     = 1'b1;
    start_ptr = PTR_W'(9);
    count     = '0;
    tick();
    start = 1'b0;
    chk("cnt0_done", 64'(done), 64'(1));
    chk("cnt0_busy", 64'(busy), 64'(0));
    chk("cnt0_valid", 64'(res_valid), 64'(0));
    chk("cnt0_read_pointer", 64'(read_pointer), 64'(6));
    tick();
    chk("cnt0_done_drop", 64'(done), 64'(0));
    chk("cnt0_still_idle", 64'(busy), 64'(0));

    for (int n = 0; n < 15; n++) begin
      int sp;
      int cnt;
      sp  = int'($urandom_range(0, 31));
      cnt = int'($urandom_range(1, 8));
      fill_random(sp, cnt);
      do_run(sp, cnt, -1, 1'b0);
    end

    // Reset while a result is pending.
    mem[3] = '{opc: MULT, op_a: -15, op_b: 15};
    start     = 1'b1;
    start_ptr = PTR_W'(3);
    count     = CNT_W'(2);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_valid", 64'(res_valid), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_read_pointer", 64'(read_pointer), 64'(0));
    chk("mid_rst_result", result, 64'(0));
    chk("mid_rst_res_ptr", 64'(res_ptr), 64'(0));
    chk("mid_rst_valid", 64'(res_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    tick();
    chk("mid_rst_no_done", 64'(done), 64'(0));
    reset_n = 1'b1;
    tick();
    chk("post_rst_no_done", 64'(done), 64'(0));
    fill_random(12, 3);
    do_run(12, 3, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
